// File: rtl/seq_packetizer.sv
// seq_packetizer: takes one whole message per handshake and serializes it
// into 32-bit words. Each packet is a length/stream header word, a sequence
// word, and then the payload packed four bytes per word. A gap-free sequence
// number is kept for each stream.
//
// Handshake rules, the same on both sides: a transfer happens in a cycle
// where valid and ready are both high. While valid is high and ready is low,
// the producer holds its data and control steady. Valid is never withdrawn
// in the middle of a packet.
module seq_packetizer #(
    parameter int NUM_STREAMS = 16,
    parameter int MAX_PAYLOAD = 40
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [15:0]              msgIn_stream,
    input  logic [15:0]              msgIn_len,
    input  logic [8*MAX_PAYLOAD-1:0] msgIn_payload,
    input  logic                     msgIn_val,
    output logic                     msgIn_ready,
    output logic [31:0]              dataOut,
    output logic                     dataOut_val,
    input  logic                     dataOut_ready,
    output logic                     dataOut_last,
    output logic                     lenErr,
    output logic [1:0]               dbg_state_o
);

    localparam int PW  = 8 * MAX_PAYLOAD;
    localparam int SW  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int WCW = $clog2(2 + MAX_PAYLOAD / 4 + 1);

    localparam logic [15:0] MAX_LEN16     = 16'(MAX_PAYLOAD);
    localparam logic [15:0] NUM_STREAMS16 = 16'(NUM_STREAMS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR0    = 2'd1;
    localparam logic [1:0] ST_HDR1    = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    logic [1:0]     state_q,  state_d;
    logic [15:0]    stream_q, stream_d;
    logic [15:0]    len_q,    len_d;
    logic [31:0]    seq_q,    seq_d;
    logic [PW-1:0]  pay_q,    pay_d;
    logic [15:0]    rem_q,    rem_d;     // payload bytes not yet sent
    logic [WCW-1:0] wcnt_q,   wcnt_d;    // index of the word now on dataOut
    logic [WCW-1:0] wlast_q,  wlast_d;   // index of the final word
    logic           lenerr_q, lenerr_d;

    logic [31:0]    cnt_q [NUM_STREAMS];
    logic           cnt_we;
    logic [SW-1:0]  cnt_idx;

    logic           accept;
    logic           bad_msg;
    logic           xfer;
    logic           at_last;
    logic [15:0]    msg_len;
    logic [15:0]    len_words;

    assign cnt_idx  = msgIn_stream[SW-1:0];
    assign accept   = msgIn_val && (state_q == ST_IDLE);
    assign bad_msg  = (msgIn_len > MAX_LEN16) || (msgIn_stream >= NUM_STREAMS16);
    assign xfer     = dataOut_val && dataOut_ready;
    assign at_last  = (wcnt_q == wlast_q);
    assign msg_len  = len_q + 16'd8;
    assign len_words = (msgIn_len + 16'd3) >> 2;

    // Next-state logic: message intake, word sequencing and payload shifting.
    always_comb begin
        state_d  = state_q;
        stream_d = stream_q;
        len_d    = len_q;
        seq_d    = seq_q;
        pay_d    = pay_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        wlast_d  = wlast_q;
        lenerr_d = 1'b0;
        cnt_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_msg) begin
                        // Offer is swallowed; only the error pulse is visible.
                        lenerr_d = 1'b1;
                    end else begin
                        stream_d = msgIn_stream;
                        len_d    = msgIn_len;
                        seq_d    = cnt_q[cnt_idx];
                        pay_d    = msgIn_payload;
                        rem_d    = msgIn_len;
                        wcnt_d   = '0;
                        wlast_d  = WCW'(len_words + 16'd1);
                        cnt_we   = 1'b1;
                        state_d  = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                if (xfer) begin
                    wcnt_d  = wcnt_q + WCW'(1);
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (xfer) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + WCW'(1);
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                        pay_d  = pay_q >> 32;
                        rem_d  = rem_q - 16'd4;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output word: headers are little-endian fields with byte 0 in the top lane.
    always_comb begin
        dataOut = '0;
        case (state_q)
            ST_HDR0:
                dataOut = {msg_len[7:0], msg_len[15:8], stream_q[7:0], stream_q[15:8]};
            ST_HDR1:
                dataOut = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
            ST_PAYLOAD: begin
                for (int k = 0; k < 4; k++) begin
                    // Bytes past the message length are sent as zero.
                    if (rem_q > 16'(k)) begin
                        dataOut[31-8*k -: 8] = pay_q[8*k +: 8];
                    end
                end
            end
            default: dataOut = '0;
        endcase
    end

    assign dataOut_val  = (state_q != ST_IDLE);
    assign dataOut_last = dataOut_val && at_last;
    assign msgIn_ready  = (state_q == ST_IDLE);
    assign lenErr       = lenerr_q;
    assign dbg_state_o  = state_q;

    // Packet registers; reset drops the output immediately.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state_q  <= ST_IDLE;
            stream_q <= '0;
            len_q    <= '0;
            seq_q    <= '0;
            pay_q    <= '0;
            rem_q    <= '0;
            wcnt_q   <= '0;
            wlast_q  <= '0;
            lenerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stream_q <= stream_d;
            len_q    <= len_d;
            seq_q    <= seq_d;
            pay_q    <= pay_d;
            rem_q    <= rem_d;
            wcnt_q   <= wcnt_d;
            wlast_q  <= wlast_d;
            lenerr_q <= lenerr_d;
        end
    end

    // Per-stream sequence counters, advanced once per accepted message.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_we) begin
            cnt_q[cnt_idx] <= cnt_q[cnt_idx] + 32'd1;
        end
    end

endmodule

// File: tb/tb_seq_packetizer.sv
// tb_seq_packetizer: directed and randomized messages against a byte-level
// packet model; checks every word, the last flag, hold under backpressure,
// error pulses and reset behaviour.
module tb_seq_packetizer;

    localparam int NS = 16;
    localparam int MP = 40;

    logic           clk;
    logic           reset_b;
    logic [15:0]    msgIn_stream;
    logic [15:0]    msgIn_len;
    logic [8*MP-1:0] msgIn_payload;
    logic           msgIn_val;
    logic           msgIn_ready;
    logic [31:0]    dataOut;
    logic           dataOut_val;
    logic           dataOut_ready;
    logic           dataOut_last;
    logic           lenErr;
    logic [1:0]     dbg_state;

    seq_packetizer #(.NUM_STREAMS(NS), .MAX_PAYLOAD(MP)) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .msgIn_stream  (msgIn_stream),
        .msgIn_len     (msgIn_len),
        .msgIn_payload (msgIn_payload),
        .msgIn_val     (msgIn_val),
        .msgIn_ready   (msgIn_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_ready (dataOut_ready),
        .dataOut_last  (dataOut_last),
        .lenErr        (lenErr),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] log_q[$];
    int unsigned exp_seq [NS];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          stall_cnt = 0;
    logic        rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Model: builds the expected word list straight from the packet format.
    task automatic push_model(input int s, input int l, input logic [8*MP-1:0] p, input int unsigned seq);
        int          nw;
        int          ml;
        logic [31:0] w;
        nw = (l + 3) / 4;
        ml = l + 8;
        w = ((ml & 255) << 24) | (((ml >> 8) & 255) << 16) | ((s & 255) << 8) | ((s >> 8) & 255);
        exp_q.push_back(w);
        exp_last_q.push_back(1'b0);
        w = ((seq & 255) << 24) | (((seq >> 8) & 255) << 16) | (((seq >> 16) & 255) << 8) | (seq >> 24);
        exp_q.push_back(w);
        exp_last_q.push_back(nw == 0);
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * j + k < l) w = w | (32'(p[8*(4*j+k) +: 8]) << (24 - 8 * k));
            end
            exp_q.push_back(w);
            exp_last_q.push_back(j == nw - 1);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!reset_b) begin
            if (prev_stall) begin
                check("hold_data", dataOut, prev_data);
                check("hold_ctl", {30'b0, dataOut_val, dataOut_last}, {30'b0, 1'b1, prev_last});
            end
            if (exp_q.size() == 0) begin
                check("idle_val", 32'(dataOut_val), 32'd0);
            end else begin
                check("busy_ctl", {30'b0, dataOut_val, msgIn_ready}, 32'd2);
                if (dataOut_val && dataOut_ready) begin
                    check("word", dataOut, exp_q.pop_front());
                    check("last", 32'(dataOut_last), 32'(exp_last_q.pop_front()));
                    log_q.push_back(dataOut);
                end
            end
            prev_stall = dataOut_val && !dataOut_ready;
            prev_data  = dataOut;
            prev_last  = dataOut_last;
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        dataOut_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                dataOut_ready = 1'b0;
                stall_cnt--;
            end else if (rand_rdy) begin
                dataOut_ready = 1'($urandom_range(0, 1));
            end else begin
                dataOut_ready = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && msgIn_ready) done = 1;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [8*MP-1:0] rand_payload();
        logic [8*MP-1:0] p;
        for (int j = 0; j < MP / 4; j++) p[32*j +: 32] = $urandom();
        return p;
    endfunction

    task automatic send(input int s, input int l);
        logic [8*MP-1:0] p;
        bit bad;
        p = rand_payload();
        bad = (l > MP) || (s >= NS);
        wait_idle();
        log_q.delete();
        msgIn_stream  = 16'(s);
        msgIn_len     = 16'(l);
        msgIn_payload = p;
        msgIn_val     = 1'b1;
        @(posedge clk);
        #1;
        msgIn_val = 1'b0;
        if (!bad) begin
            push_model(s, l, p, exp_seq[s]);
            exp_seq[s]++;
        end else begin
            @(negedge clk);
            check("err_pulse", 32'(lenErr), 32'd1);
            check("err_noval", 32'(dataOut_val), 32'd0);
            @(negedge clk);
            check("err_end", 32'(lenErr), 32'd0);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < NS; i++) exp_seq[i] = 0;
        prev_stall = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_b       = 1'b1;
        msgIn_stream  = '0;
        msgIn_len     = '0;
        msgIn_payload = '0;
        msgIn_val     = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #2 reset_b = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(msgIn_ready), 32'd1);
        check("rst_data", dataOut, 32'd0);
        check("rst_ctl", {29'b0, dataOut_val, dataOut_last, lenErr}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Stream 12 back to back: len 12, 12, 13.
        send(12, 12);
        wait_idle();
        check("p1_cnt", 32'(log_q.size()), 32'd5);
        if (log_q.size() == 5) begin
            check("p1_hdr", log_q[0], 32'h14000C00);
            check("p1_seq", log_q[1], 32'h00000000);
        end
        send(12, 12);
        wait_idle();
        if (log_q.size() >= 2) check("p2_seq", log_q[1], 32'h01000000);
        send(12, 13);
        wait_idle();
        check("p3_cnt", 32'(log_q.size()), 32'd6);
        if (log_q.size() == 6) begin
            check("p3_hdr", log_q[0], 32'h15000C00);
            check("p3_seq", log_q[1], 32'h02000000);
            check("p3_tail", log_q[5] & 32'h00FFFFFF, 32'd0);
        end

        // Interleaved stream 14, then stream 12 resumes.
        send(14, 15);
        wait_idle();
        if (log_q.size() >= 2) begin
            check("s14_hdr", log_q[0], 32'h17000E00);
            check("s14_seq", log_q[1], 32'h00000000);
        end
        send(12, 8);
        wait_idle();
        if (log_q.size() >= 2) check("s12_seq3", log_q[1], 32'h03000000);

        // Backpressure mid-payload.
        send(12, 40);
        repeat (4) @(posedge clk);
        stall_cnt = 5;
        wait_idle();
        check("bp_cnt", 32'(log_q.size()), 32'd12);

        // Rejected offers, then stream 12 continues in sequence.
        send(12, 41);
        send(16, 5);
        send(12, 4);
        wait_idle();
        if (log_q.size() >= 2) check("after_err_seq", log_q[1], 32'h05000000);

        // Zero-length message.
        send(15, 0);
        wait_idle();
        check("len0_cnt", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) check("len0_hdr", log_q[0], 32'h08000F00);

        // Randomized traffic with random downstream ready.
        rand_rdy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            send($urandom_range(0, NS + 1), $urandom_range(0, MP + 3));
        end
        wait_idle();
        rand_rdy = 1'b0;

        // Reset in the middle of a payload.
        send(12, 40);
        repeat (4) @(negedge clk);
        #2 reset_b = 1'b1;
        #1;
        check("rst_mid_val", 32'(dataOut_val), 32'd0);
        check("rst_mid_last", 32'(dataOut_last), 32'd0);
        clear_model();
        @(posedge clk);
        #2 reset_b = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(msgIn_ready), 32'd1);
        send(12, 8);
        wait_idle();
        if (log_q.size() >= 2) check("rst_seq0", log_q[1], 32'h00000000);

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
